// File: rtl/conv_pkg.sv
// Shared types and sizes for the convolution result sequencer.
package conv_pkg;

  localparam int unsigned NUM_OUT_CH = 8;
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned CH_W       = 3;
  localparam int unsigned OC_W       = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    REQ,
    WR,
    POOL,
    DUMP,
    FIN
  } state_e;

endpackage

// File: rtl/conv_bias_regs.sv
// Per-output-channel bias storage: one synchronous write port, one combinational read port.
module conv_bias_regs
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [CH_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [CH_W-1:0]   raddr,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem [NUM_OUT_CH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_OUT_CH); i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/conv_sequencer.sv
// Sequences clear / MAC-accumulate / pool / dump commands to the result register file.
// Build macro CONV_SEQ_DUMP_EN enables the DUMP state and the cout_done strobe.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned CHANNEL_SIZE = 784,
  parameter int unsigned NUM_IN_CH    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              bias_we,
  input  logic [CH_W-1:0]   bias_waddr,
  input  logic [DATA_W-1:0] bias_wdata,
  output logic              mac_req,
  output logic [CH_W-1:0]   mac_ic,
  input  logic              mac_valid,
  input  logic [DATA_W-1:0] mac_value,
  output logic              store,
  output logic              pool,
  output logic              first_write,
  output logic              cout_done,
  output logic [OC_W-1:0]   out_c,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] value,
  output logic [DATA_W-1:0] bias,
  input  logic              pool_done,
  output logic              busy,
  output logic              done
);

`ifdef CONV_SEQ_DUMP_EN
  localparam bit DUMP_EN = 1'b1;
`else
  localparam bit DUMP_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CHANNEL_SIZE - 1);
  localparam logic [ADDR_W-1:0] LAST_POOL = ADDR_W'(CHANNEL_SIZE - 4);
  localparam logic [CH_W-1:0]   LAST_IC   = CH_W'(NUM_IN_CH - 1);
  localparam logic [OC_W-1:0]   LAST_OC   = OC_W'(NUM_OUT_CH - 1);

  state_e              state_q, nxt_state;
  logic [ADDR_W-1:0]   addr_q, nxt_addr;
  logic [CH_W-1:0]     ic_q, nxt_ic;
  logic [OC_W-1:0]     outc_q, nxt_outc;

  logic                store_q, pool_q, fw_q, mac_req_q, busy_q, done_q;
  logic [DATA_W-1:0]   value_q, bias_q;
  logic                nxt_store, nxt_pool, nxt_fw, nxt_mac_req, nxt_busy, nxt_done;
  logic [DATA_W-1:0]   nxt_value, nxt_bias;
  logic [DATA_W-1:0]   bias_rd_c;

  conv_bias_regs u_bias_regs (
    .clk     (clk),
    .rst     (rst),
    .we      (bias_we),
    .waddr   (bias_waddr),
    .wdata   (bias_wdata),
    .raddr   (outc_q[CH_W-1:0]),
    .rdata_c (bias_rd_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      ic_q      <= '0;
      outc_q    <= '0;
      store_q   <= 1'b0;
      pool_q    <= 1'b0;
      fw_q      <= 1'b0;
      mac_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      value_q   <= '0;
      bias_q    <= '0;
    end else begin
      state_q   <= nxt_state;
      addr_q    <= nxt_addr;
      ic_q      <= nxt_ic;
      outc_q    <= nxt_outc;
      store_q   <= nxt_store;
      pool_q    <= nxt_pool;
      fw_q      <= nxt_fw;
      mac_req_q <= nxt_mac_req;
      busy_q    <= nxt_busy;
      done_q    <= nxt_done;
      value_q   <= nxt_value;
      bias_q    <= nxt_bias;
    end
  end

  always_comb begin
    nxt_state = state_q;
    nxt_addr  = addr_q;
    nxt_ic    = ic_q;
    nxt_outc  = outc_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          nxt_state = CLEAR;
          nxt_addr  = '0;
          nxt_ic    = '0;
          nxt_outc  = '0;
        end
      end
      CLEAR: begin
        if (addr_q == LAST_ADDR) begin
          nxt_state = REQ;
          nxt_addr  = '0;
          nxt_ic    = '0;
        end else begin
          nxt_addr = addr_q + ADDR_W'(1);
        end
      end
      REQ: begin
        if (mac_valid) nxt_state = WR;
      end
      WR: begin
        // Walk addr, then input channel, then output channel
        nxt_state = REQ;
        if (addr_q != LAST_ADDR) begin
          nxt_addr = addr_q + ADDR_W'(1);
        end else begin
          nxt_addr = '0;
          if (ic_q != LAST_IC) begin
            nxt_ic = ic_q + CH_W'(1);
          end else begin
            nxt_ic = '0;
            if (outc_q != LAST_OC) begin
              nxt_outc  = outc_q + OC_W'(1);
              nxt_state = CLEAR;
            end else begin
              nxt_outc  = '0;
              nxt_state = POOL;
            end
          end
        end
      end
      POOL: begin
        if (pool_done || (addr_q == LAST_POOL)) begin
          nxt_state = DUMP_EN ? DUMP : FIN;
          nxt_addr  = '0;
        end else begin
          nxt_addr = addr_q + ADDR_W'(4);
        end
      end
      DUMP:    nxt_state = FIN;
      FIN:     nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase

    // Abort dominates everything, including a simultaneous start
    if (abort) begin
      nxt_state = IDLE;
      nxt_addr  = '0;
      nxt_ic    = '0;
      nxt_outc  = '0;
    end

    nxt_store   = (nxt_state == CLEAR) || (nxt_state == WR);
    nxt_fw      = (nxt_state == CLEAR);
    nxt_pool    = (nxt_state == POOL);
    nxt_mac_req = (nxt_state == REQ);
    nxt_done    = (nxt_state == FIN);
    nxt_busy    = (nxt_state != IDLE);
    nxt_value   = '0;
    nxt_bias    = '0;
    if (nxt_state == WR) begin
      nxt_value = mac_value;
      // Bypass a write landing on the same edge we enter WR
      nxt_bias  = (bias_we && (bias_waddr == outc_q[CH_W-1:0])) ? bias_wdata : bias_rd_c;
    end
  end

`ifdef CONV_SEQ_DUMP_EN
  logic cout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cout_q <= 1'b0;
    else      cout_q <= (nxt_state == DUMP);
  end

  assign cout_done = cout_q;
`else
  assign cout_done = 1'b0;
`endif

  assign mac_req     = mac_req_q;
  assign mac_ic      = ic_q;
  assign store       = store_q;
  assign pool        = pool_q;
  assign first_write = fw_q;
  assign out_c       = outc_q;
  assign addr        = addr_q;
  assign value       = value_q;
  assign bias        = bias_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer with CHANNEL_SIZE=8, NUM_IN_CH=1.
module tb_conv_sequencer;

  localparam int unsigned CS  = 8;
  localparam int unsigned NIC = 1;

`ifdef CONV_SEQ_DUMP_EN
  localparam int DUMP_EN = 1;
`else
  localparam int DUMP_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, abort, bias_we, mac_valid, pool_done;
  logic [2:0] bias_waddr;
  logic [7:0] bias_wdata, mac_value;
  logic       mac_req, store, pool, first_write, cout_done, busy, done;
  logic [2:0] mac_ic;
  logic [3:0] out_c;
  logic [9:0] addr;
  logic [7:0] value, bias;

  int errors = 0;
  int checks = 0;

  int n_clr, n_wr, n_pool, n_cout, n_done, done_idx;
  int bad_addr, bad_bias, bad_val, bad_excl, bad_gap;
  int pool_addr0, pool_addr1;

  conv_sequencer #(.CHANNEL_SIZE(CS), .NUM_IN_CH(NIC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .bias_we(bias_we), .bias_waddr(bias_waddr), .bias_wdata(bias_wdata),
    .mac_req(mac_req), .mac_ic(mac_ic), .mac_valid(mac_valid), .mac_value(mac_value),
    .store(store), .pool(pool), .first_write(first_write), .cout_done(cout_done),
    .out_c(out_c), .addr(addr), .value(value), .bias(bias),
    .pool_done(pool_done), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs a job already started on the previous edge, collecting command statistics
  task automatic run_job(input int budget, input int start_busy_at, input logic [7:0] exp_b2);
    int clr_in_ch, wr_in_ch, last_wr;
    logic [7:0] exp_bias;
    n_clr = 0; n_wr = 0; n_pool = 0; n_cout = 0; n_done = 0; done_idx = -1;
    bad_addr = 0; bad_bias = 0; bad_val = 0; bad_excl = 0; bad_gap = 0;
    pool_addr0 = -1; pool_addr1 = -1;
    clr_in_ch = 0; wr_in_ch = 0; last_wr = -10;
    for (int i = 0; i < budget; i++) begin
      tick();
      start = (i == start_busy_at);
      if (int'(store) + int'(pool) + int'(cout_done) > 1) bad_excl++;
      if (store && first_write) begin
        if (addr != 10'(clr_in_ch)) bad_addr++;
        clr_in_ch++;
        n_clr++;
        if (clr_in_ch == int'(CS)) begin
          clr_in_ch = 0;
          wr_in_ch  = 0;
        end
      end
      if (store && !first_write) begin
        if (addr != 10'(wr_in_ch)) bad_addr++;
        if (wr_in_ch > 0 && (i - last_wr) != 2) bad_gap++;
        if (value !== 8'h33) bad_val++;
        exp_bias = (out_c == 4'd2) ? exp_b2 : 8'h00;
        if (bias !== exp_bias) bad_bias++;
        wr_in_ch++;
        last_wr = i;
        n_wr++;
      end
      if (pool) begin
        if (n_pool == 0) pool_addr0 = int'(addr);
        if (n_pool == 1) pool_addr1 = int'(addr);
        n_pool++;
      end
      if (cout_done) n_cout++;
      if (done) begin
        n_done++;
        done_idx = i;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    bit found;
    rst = 1'b0; start = 1'b0; abort = 1'b0; bias_we = 1'b0;
    bias_waddr = 3'd0; bias_wdata = 8'h00;
    mac_valid = 1'b1; mac_value = 8'h33; pool_done = 1'b0;

    // Reset state
    tick();
    tick();
    check("reset_cmds", 32'({store, pool, first_write, cout_done, mac_req, busy, done}), 32'd0);
    check("reset_operands", 32'({out_c, addr, value, bias, mac_ic}), 32'd0);
    rst = 1'b1;
    tick();
    check("idle_after_release", 32'({store, busy, done}), 32'd0);

    // Bias load before start, then full job with mac_valid tied high
    bias_we = 1'b1; bias_waddr = 3'd2; bias_wdata = 8'h11;
    tick();
    bias_we = 1'b0;
    start = 1'b1;
    run_job(400, -1, 8'h11);
    check("job1_clear_stores", 32'(n_clr), 32'd64);
    check("job1_wr_stores", 32'(n_wr), 32'd64);
    check("job1_addr_seq", 32'(bad_addr), 32'd0);
    check("job1_wr_gap", 32'(bad_gap), 32'd0);
    check("job1_value", 32'(bad_val), 32'd0);
    check("job1_bias", 32'(bad_bias), 32'd0);
    check("job1_exclusive", 32'(bad_excl), 32'd0);
    check("job1_pool_count", 32'(n_pool), 32'd2);
    check("job1_pool_addr0", 32'(pool_addr0), 32'd0);
    check("job1_pool_addr1", 32'(pool_addr1), 32'd4);
    check("job1_cout_done", 32'(n_cout), 32'(DUMP_EN));
    check("job1_done_count", 32'(n_done), 32'd1);
    check("job1_done_cycle", 32'(done_idx), 32'(194 + DUMP_EN));
    tick();
    check("job1_idle_after", 32'({busy, done, store, pool, cout_done}), 32'd0);

    // mac_valid withheld at addr 3: request must hold with stable operands
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (store && !first_write && addr == 10'd2) begin
        found = 1'b1;
        break;
      end
    end
    check("delay_reach_addr2", 32'(found), 32'd1);
    mac_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("delay_hold_req", 32'({mac_req, store, out_c, addr}), 32'({1'b1, 1'b0, 4'd0, 10'd3}));
    end
    mac_valid = 1'b1; mac_value = 8'h5A;
    tick();
    check("delay_store", 32'({store, first_write, addr, value}), 32'({1'b1, 1'b0, 10'd3, 8'h5A}));
    mac_value = 8'h33;

    // Abort (with a simultaneous start) during out_c=3 REQ
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (mac_req && out_c == 4'd3) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reach_oc3", 32'(found), 32'd1);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort_idle", 32'({busy, mac_req, store, pool, done, cout_done}), 32'd0);
    check("abort_operands", 32'({out_c, addr}), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("abort_quiet", 32'({busy, mac_req, store, pool, done, cout_done}), 32'd0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_clear", 32'({store, first_write, busy, out_c, addr}), 32'({1'b1, 1'b1, 1'b1, 4'd0, 10'd0}));

    // Asynchronous reset mid-CLEAR
    tick();
    tick();
    check("mid_clear_addr", 32'({store, first_write, addr}), 32'({1'b1, 1'b1, 10'd2}));
    #2;
    rst = 1'b0;
    #1;
    check("rst_cmds", 32'({store, pool, first_write, cout_done, mac_req, busy, done}), 32'd0);
    check("rst_operands", 32'({out_c, addr, value, bias, mac_ic}), 32'd0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_release_quiet", 32'({busy, store, pool, done, cout_done}), 32'd0);
    end

    // Full job after reset: bias cleared, early pool_done, start while busy ignored
    pool_done = 1'b1;
    start = 1'b1;
    run_job(400, 50, 8'h00);
    pool_done = 1'b0;
    check("job2_clear_stores", 32'(n_clr), 32'd64);
    check("job2_wr_stores", 32'(n_wr), 32'd64);
    check("job2_addr_seq", 32'(bad_addr), 32'd0);
    check("job2_bias_cleared", 32'(bad_bias), 32'd0);
    check("job2_exclusive", 32'(bad_excl), 32'd0);
    check("job2_pool_count", 32'(n_pool), 32'd1);
    check("job2_pool_addr0", 32'(pool_addr0), 32'd0);
    check("job2_cout_done", 32'(n_cout), 32'(DUMP_EN));
    check("job2_done_count", 32'(n_done), 32'd1);
    check("job2_done_cycle", 32'(done_idx), 32'(193 + DUMP_EN));
    tick();
    check("job2_idle_after", 32'({busy, done, store}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 SHALL have parameter CHANNEL_SIZE, default 784, meaning pixels per output-channel map; SHALL be a multiple of 4 and ≤1024.
REQ-002 SHALL have parameter NUM_IN_CH, default 1, meaning input channels accumulated per output channel (1..8).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, meaning a one-cycle job-start request.
REQ-006 SHALL have port abort, input, 1, meaning synchronous job cancel.
REQ-007 SHALL have ports bias_we (input, 1), bias_waddr (input, 3) and bias_wdata (input, 8), meaning the per-output-channel bias load port.
REQ-008 SHALL have ports mac_req (output, 1), mac_ic (output, 3), mac_valid (input, 1) and mac_value (input, 8), meaning the MAC-result handshake.
REQ-009 SHALL have ports store, pool and first_write (output, 1 each), meaning commands to the result register file.
REQ-010 SHALL have port cout_done, output, 1, meaning the result-dump strobe.
REQ-011 SHALL have ports out_c (output, 4), addr (output, 10), value (output, 8) and bias (output, 8), meaning the command operands.
REQ-012 SHALL have ports pool_done (input, 1), busy (output, 1) and done (output, 1, one-cycle pulse), meaning pool completion and job status.

Function
REQ-013 States SHALL be IDLE, CLEAR, REQ, WR, POOL, DUMP, FIN.
- IDLE→CLEAR on start & !abort; start while busy is ignored.
REQ-014 CLEAR SHALL assert store=1, first_write=1 for CHANNEL_SIZE consecutive cycles.
- addr 0..CHANNEL_SIZE-1, one per cycle; then →REQ with addr=0, ic=0.
REQ-015 REQ SHALL hold mac_req=1 with out_c, mac_ic, addr stable until mac_valid is sampled high, then capture mac_value and →WR.
REQ-016 WR SHALL last exactly one cycle: store=1, first_write=0, value=captured mac_value, bias=bias[out_c].
- Store follows the mac_valid cycle by exactly 1 cycle.
REQ-017 After WR, addr SHALL increment.
- At addr=CHANNEL_SIZE-1: addr wraps to 0 and ic increments.
- At ic=NUM_IN_CH-1: out_c increments and →CLEAR.
- At out_c=7: →POOL with addr=0.
REQ-018 POOL SHALL assert pool=1 each cycle with addr=0,4,…,CHANNEL_SIZE-4.
- Leaves after the last address or on pool_done=1, whichever comes first: →DUMP.
REQ-019 DUMP SHALL assert cout_done=1 for one cycle, then →FIN.
- FIN pulses done=1 for one cycle, then →IDLE.
REQ-020 store, pool and cout_done SHALL be mutually exclusive in every cycle.
- store/pool/cout_done/mac_req SHALL be 0 in IDLE and FIN.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 abort SHALL force IDLE next cycle from any state, with no further command pulses; abort wins over a simultaneous start.
REQ-023 A bias write SHALL take effect the next cycle and is permitted at any time.
- A write to the current out_c during WR uses the old value.

Reset
REQ-024 On rst=0: state=IDLE; all outputs 0; out_c, addr, ic 0; bias file cleared to 0.
- Reset mid-job abandons it; no pulse is emitted on release.

Configuration
REQ-025 The feature macro SHALL be CONV_SEQ_DUMP_EN.
- Defined: DUMP state exists per REQ-019.
- Undefined: POOL→FIN directly, and cout_done is tied 0.

Structure
REQ-026 Package conv_pkg SHALL hold the state enum, NUM_OUT_CH=8, ADDR_W=10 and DATA_W=8.
REQ-027 The 8×8 bias storage SHALL be sub-module conv_bias_regs: one write port, one combinational read port.

Verification
REQ-028 CHANNEL_SIZE=8, NUM_IN_CH=1, start, with mac_valid tied 1 → per out_c: 8 CLEAR stores, then 8 WR stores 2 cycles apart.
- Then 2 pool pulses (addr 0,4), one cout_done, one done.
REQ-029 mac_valid delayed 5 cycles at addr=3 → mac_req held for 5 cycles with addr=3 stable; store occurs 1 cycle after mac_valid with value=mac_value (0x5A).
REQ-030 bias_waddr=2, bias_wdata=0x11 before start → every WR with out_c=2 presents bias=0x11; other channels present 0.
REQ-031 abort asserted during out_c=3 REQ → IDLE next cycle, busy=0; start then restarts at out_c=0, addr=0.
REQ-032 pool_done=1 on the first pool cycle → exactly one pool pulse, then cout_done (macro defined) or done (macro undefined).
REQ-033 rst=0 mid-CLEAR → all outputs 0 immediately; start after release runs a complete job.
